// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO over valid/ready and are
// shifted out LSB first at BAUD_DIVIDER_COUNT clocks per bit.
module uart_tx_fifo #(
    parameter int unsigned BAUD_DIVIDER_COUNT = 10,
    parameter int unsigned FIFO_DEPTH         = 16,
    parameter int unsigned STOP_BITS          = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    input  logic [7:0]                    i_data,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(BAUD_DIVIDER_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    state_t        state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic          stop_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;

    logic push;
    logic pop;
    logic baud_last;
    logic stop_last;

    assign o_ready   = (count_q != (AW+1)'(FIFO_DEPTH));
    assign push      = i_valid & o_ready;
    assign baud_last = (baud_q == CW'(BAUD_DIVIDER_COUNT - 1));
    assign stop_last = (stop_q == 1'(STOP_BITS - 1));
    // Head is taken from IDLE or straight out of the final stop cycle, so
    // queued frames follow each other without an idle bit.
    assign pop = (count_q != '0) &&
                 ((state_q == IDLE) || ((state_q == STOP) && baud_last && stop_last));

    assign o_tx    = tx_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_count = count_q;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Line outputs are registered from the current state, so the pin trails
    // the state by one clock; o_done lands in the last stop cycle on the pin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        baud_q  <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    tx_q <= shift_q[bit_q];
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            stop_q  <= '0;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (baud_last) begin
                        baud_q <= '0;
                        if (stop_last) begin
                            done_q <= 1'b1;
                            if (pop) begin
                                shift_q <= mem_q[rd_ptr_q];
                                state_q <= START;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            stop_q <= stop_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
